pid_wb_master: RTL and testbench

- Wishbone Classic master that programs and drives the PID slave over its 32-bit Wishbone port.
- Loads gains and setpoint on request.
- For each new process-value sample: writes PV, reads back u(n) (the slave holds off its ack until computation completes), and presents u(n) with a one-cycle valid strobe.
- Sits between the sensor/actuator glue logic and the PID slave.

---
 rtl/pid_wb_if.sv | 23 ++
 rtl/pid_wb_master.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pid_wb_master.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_wb_if.sv
// Wishbone Classic bus between pid_wb_master and the PID slave.
// The master drives cyc/stb/we/adr/data; the slave returns ack and read data.
interface pid_wb_if #(
  parameter int ADR_NB = 16
);
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADR_NB-1:0] o_wb_adr;
  logic [31:0]       o_wb_data;
  logic              i_wb_ack;
  logic [31:0]       i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
    input  i_wb_ack, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_data,
    output i_wb_ack, i_wb_data
  );
endinterface

// File: rtl/pid_wb_master.sv
// Wishbone Classic master that configures the PID slave and, for every new
// process-value sample, writes PV and reads back u(n).
// Optional: define PID_OF_READBACK_EN to also read the slave overflow flags
// after each u(n) read; o_un and o_of then update together.
module pid_wb_master #(
  parameter int ADR_NB  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cfg_start,
  input  logic [15:0] i_kp,
  input  logic [15:0] i_ki,
  input  logic [15:0] i_kd,
  input  logic [15:0] i_sp,
  input  logic        i_clear,
  input  logic        i_pv_valid,
  input  logic [15:0] i_pv,
  output logic        o_busy,
  output logic [31:0] o_un,
  output logic        o_un_valid,
  output logic        o_drop,
  output logic        o_err,
  output logic [4:0]  o_of,
  pid_wb_if.master    wb
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [5:0] A_PV = 6'h10;
  localparam logic [5:0] A_UN = 6'h20;
  localparam logic [5:0] A_OF = 6'h28;
  localparam logic [5:0] A_RS = 6'h2C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_CLR,
    S_PV_WR,
    S_UN_RD,
`ifdef PID_OF_READBACK_EN
    S_OF_RD,
`endif
    S_GAP
  } state_t;

  // 16-bit register values travel as sign-extended 32-bit words.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  state_t            state_q, state_d, ret_q, ret_d;
  logic [1:0]        idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       kp_q, kp_d, ki_q, ki_d, kd_q, kd_d, sp_q, sp_d, pv_q, pv_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [ADR_NB-1:0] adr_q, adr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       un_q, un_d;
  logic              un_valid_q, un_valid_d, drop_q, drop_d, err_q, err_d;
  logic              ack, req_any, timeout;
`ifdef PID_OF_READBACK_EN
  logic [31:0]       un_pend_q, un_pend_d;
  logic [4:0]        of_q, of_d;
`endif

  // Ack only counts while a strobe is out; an ack in IDLE/GAP is ignored by the FSM.
  assign ack     = wb.i_wb_ack;
  assign req_any = i_cfg_start | i_clear | i_pv_valid;

  // Sequencer: request acceptance, transaction progress, drop and timeout handling.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    idx_d      = idx_q;
    kp_d       = kp_q;
    ki_d       = ki_q;
    kd_d       = kd_q;
    sp_d       = sp_q;
    pv_d       = pv_q;
    un_d       = un_q;
    un_valid_d = 1'b0;
    drop_d     = 1'b0;
    err_d      = err_q;
`ifdef PID_OF_READBACK_EN
    un_pend_d  = un_pend_q;
    of_d       = of_q;
`endif
    // Counter is zero whenever stb is low, so it restarts with every strobe.
    cnt_d   = (stb_q && !ack) ? cnt_q + CW'(1) : '0;
    timeout = stb_q && !ack && (cnt_q == CW'(TIMEOUT - 1));

    case (state_q)
      S_IDLE: begin
        if (i_cfg_start) begin
          kp_d    = i_kp;
          ki_d    = i_ki;
          kd_d    = i_kd;
          sp_d    = i_sp;
          idx_d   = 2'd0;
          err_d   = 1'b0;
          state_d = S_CFG;
          drop_d  = i_clear | i_pv_valid;
        end else if (i_clear) begin
          state_d = S_CLR;
          drop_d  = i_pv_valid;
        end else if (i_pv_valid) begin
          pv_d    = i_pv;
          state_d = S_PV_WR;
        end
      end
      S_GAP: begin
        drop_d  = req_any;
        state_d = ret_q;
      end
      S_CFG: begin
        drop_d = req_any;
        if (ack) begin
          state_d = S_GAP;
          if (idx_q == 2'd3) begin
            ret_d = S_IDLE;
          end else begin
            ret_d = S_CFG;
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_CLR: begin
        drop_d = req_any;
        if (ack) begin
          state_d = S_GAP;
          ret_d   = S_IDLE;
        end
      end
      S_PV_WR: begin
        drop_d = req_any;
        if (ack) begin
          state_d = S_GAP;
          ret_d   = S_UN_RD;
        end
      end
      S_UN_RD: begin
        drop_d = req_any;
        if (ack) begin
          state_d = S_GAP;
`ifdef PID_OF_READBACK_EN
          un_pend_d = wb.i_wb_data;
          ret_d     = S_OF_RD;
`else
          un_d       = wb.i_wb_data;
          un_valid_d = 1'b1;
          ret_d      = S_IDLE;
`endif
        end
      end
`ifdef PID_OF_READBACK_EN
      S_OF_RD: begin
        drop_d = req_any;
        if (ack) begin
          state_d    = S_GAP;
          ret_d      = S_IDLE;
          un_d       = un_pend_q;
          of_d       = wb.i_wb_data[4:0];
          un_valid_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // A stuck transaction abandons the rest of the sequence.
    if (timeout) begin
      err_d   = 1'b1;
      state_d = S_GAP;
      ret_d   = S_IDLE;
    end
  end

  // Bus word for the upcoming cycle, derived from the next state so it is registered.
  always_comb begin
    cyc_d  = 1'b0;
    stb_d  = 1'b0;
    we_d   = 1'b0;
    adr_d  = '0;
    wdat_d = '0;
    case (state_d)
      S_CFG: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = 1'b1;
        adr_d = ADR_NB'({idx_d, 2'b00});
        case (idx_d)
          2'd0:    wdat_d = sext16(kp_d);
          2'd1:    wdat_d = sext16(ki_d);
          2'd2:    wdat_d = sext16(kd_d);
          default: wdat_d = sext16(sp_d);
        endcase
      end
      S_CLR: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        we_d  = 1'b1;
        adr_d = ADR_NB'(A_RS);
      end
      S_PV_WR: begin
        cyc_d  = 1'b1;
        stb_d  = 1'b1;
        we_d   = 1'b1;
        adr_d  = ADR_NB'(A_PV);
        wdat_d = sext16(pv_d);
      end
      S_UN_RD: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        adr_d = ADR_NB'(A_UN);
      end
`ifdef PID_OF_READBACK_EN
      S_OF_RD: begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
        adr_d = ADR_NB'(A_OF);
      end
`endif
      default: ;
    endcase
  end

  // State, captured values and registered bus outputs; reset drops the bus at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      kd_q       <= '0;
      sp_q       <= '0;
      pv_q       <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      un_q       <= '0;
      un_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PID_OF_READBACK_EN
      un_pend_q  <= '0;
      of_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      kd_q       <= kd_d;
      sp_q       <= sp_d;
      pv_q       <= pv_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      un_q       <= un_d;
      un_valid_q <= un_valid_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
`ifdef PID_OF_READBACK_EN
      un_pend_q  <= un_pend_d;
      of_q       <= of_d;
`endif
    end
  end

  assign wb.o_wb_cyc  = cyc_q;
  assign wb.o_wb_stb  = stb_q;
  assign wb.o_wb_we   = we_q;
  assign wb.o_wb_adr  = adr_q;
  assign wb.o_wb_data = wdat_q;

  assign o_busy     = (state_q != S_IDLE);
  assign o_un       = un_q;
  assign o_un_valid = un_valid_q;
  assign o_drop     = drop_q;
  assign o_err      = err_q;
`ifdef PID_OF_READBACK_EN
  assign o_of = of_q;
`else
  assign o_of = 5'd0;
`endif
endmodule

// File: tb/tb_pid_wb_master.sv
// Self-checking bench for pid_wb_master: a latency-programmable Wishbone slave
// model, a bus monitor that logs completed transfers, and an expected-transfer
// list built from the register map for each request.
module tb_pid_wb_master;
  localparam int TO = 20;

  typedef struct packed {
    logic        we;
    logic [15:0] adr;
    logic [31:0] dat;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg, clr, pvv;
  logic [15:0] kp, ki, kd, sp, pv;
  logic        o_busy, o_un_valid, o_drop, o_err;
  logic [31:0] o_un;
  logic [4:0]  o_of;

  always #5 clk = ~clk;

  pid_wb_if #(.ADR_NB(16)) wb ();

  pid_wb_master #(.ADR_NB(16), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_start(cfg), .i_kp(kp), .i_ki(ki), .i_kd(kd), .i_sp(sp),
    .i_clear(clr), .i_pv_valid(pvv), .i_pv(pv),
    .o_busy(o_busy), .o_un(o_un), .o_un_valid(o_un_valid), .o_drop(o_drop),
    .o_err(o_err), .o_of(o_of), .wb(wb)
  );

  int checks = 0;
  int failures = 0;

  // slave model controls
  int          lat_wr = 1, lat_rd = 1, wcnt = 0;
  bit          noack_un = 1'b0, stray_ack = 1'b0;
  logic [31:0] un_val = 32'h0, of_val = 32'h0;

  // monitor state
  int          stb_run = 0, last_len = 0, gap_viol = 0, stab_viol = 0, cyc_viol = 0;
  int          unv_hi = 0, drop_hi = 0;
  logic        after_ack = 1'b0, h_we = 1'b0;
  logic [15:0] h_adr = 16'h0;
  logic [31:0] h_dat = 32'h0, un_at_valid = 32'h0;
  tx_t         txq[$];
  tx_t         expq[$];

  // reference model state
  logic [31:0] exp_un = 32'h0;
  logic [4:0]  exp_of = 5'h0;

  // Slave: ack after a programmable wait, optionally never for the u(n) read.
  always @(posedge clk) begin
    if (wb.o_wb_stb && !wb.i_wb_ack) begin
      if (!(noack_un && wb.o_wb_adr == 16'h0020) && wcnt >= (wb.o_wb_we ? lat_wr : lat_rd)) begin
        wb.i_wb_ack  <= 1'b1;
        wb.i_wb_data <= (wb.o_wb_adr == 16'h0020) ? un_val :
                        (wb.o_wb_adr == 16'h0028) ? of_val : 32'hDEAD_BEEF;
        wcnt <= 0;
      end else begin
        wb.i_wb_ack <= 1'b0;
        wcnt <= wcnt + 1;
      end
    end else begin
      wb.i_wb_ack <= stray_ack;
      if (!wb.o_wb_stb) wcnt <= 0;
    end
  end

  // Monitor: completed transfers, strobe lengths, bus stability, idle gaps, strobes.
  always @(negedge clk) begin
    if (wb.o_wb_stb) begin
      if (stb_run == 0) begin
        h_adr <= wb.o_wb_adr;
        h_we  <= wb.o_wb_we;
        h_dat <= wb.o_wb_data;
      end else if (wb.o_wb_adr !== h_adr || wb.o_wb_we !== h_we || wb.o_wb_data !== h_dat) begin
        stab_viol <= stab_viol + 1;
      end
      if (wb.i_wb_ack) begin
        txq.push_back(tx_t'{wb.o_wb_we, wb.o_wb_adr, wb.o_wb_data});
        last_len <= stb_run + 1;
        stb_run  <= 0;
      end else begin
        stb_run <= stb_run + 1;
      end
    end else begin
      if (stb_run != 0) last_len <= stb_run;
      stb_run <= 0;
    end
    if (wb.o_wb_cyc !== wb.o_wb_stb) cyc_viol <= cyc_viol + 1;
    if (after_ack && wb.o_wb_stb) gap_viol <= gap_viol + 1;
    after_ack <= wb.o_wb_stb && wb.i_wb_ack;
    if (o_un_valid) begin
      unv_hi      <= unv_hi + 1;
      un_at_valid <= o_un;
    end
    if (o_drop) drop_hi <= drop_hi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    logic signed [31:0] t;
    t = $signed(v);
    return t;
  endfunction

  task automatic exp_cfg(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    expq.push_back(tx_t'{1'b1, 16'h0000, sx(a)});
    expq.push_back(tx_t'{1'b1, 16'h0004, sx(b)});
    expq.push_back(tx_t'{1'b1, 16'h0008, sx(c)});
    expq.push_back(tx_t'{1'b1, 16'h000C, sx(d)});
  endtask

  task automatic exp_clr();
    expq.push_back(tx_t'{1'b1, 16'h002C, 32'h0});
  endtask

  task automatic exp_pv(input logic [15:0] v);
    expq.push_back(tx_t'{1'b1, 16'h0010, sx(v)});
    expq.push_back(tx_t'{1'b0, 16'h0020, 32'h0});
`ifdef PID_OF_READBACK_EN
    expq.push_back(tx_t'{1'b0, 16'h0028, 32'h0});
    exp_of = of_val[4:0];
`endif
    exp_un = un_val;
  endtask

  task automatic cmp_txs(input string tag);
    chk({tag, "_ntx"}, txq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < txq.size(); i++) begin
      chk($sformatf("%s_we%0d", tag, i), 32'(txq[i].we), 32'(expq[i].we));
      chk($sformatf("%s_adr%0d", tag, i), 32'(txq[i].adr), 32'(expq[i].adr));
      if (expq[i].we) chk($sformatf("%s_dat%0d", tag, i), txq[i].dat, expq[i].dat);
    end
    txq.delete();
    expq.delete();
  endtask

  task automatic req(input logic c, input logic cl, input logic p);
    @(negedge clk);
    cfg = c; clr = cl; pvv = p;
    @(negedge clk);
    cfg = 1'b0; clr = 1'b0; pvv = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (o_busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(o_busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic rnd_cfg_vals();
    kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom); sp = 16'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, u0, kind, n;
    rst_n = 1'b0; cfg = 1'b0; clr = 1'b0; pvv = 1'b0;
    kp = '0; ki = '0; kd = '0; sp = '0; pv = '0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_cyc", 32'(wb.o_wb_cyc), 0);
    chk("rst_stb", 32'(wb.o_wb_stb), 0);
    chk("rst_un", o_un, 0);
    chk("rst_unv", 32'(o_un_valid), 0);
    chk("rst_drop", 32'(o_drop), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_of", 32'(o_of), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ack with no strobe outstanding must be ignored
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_busy", 32'(o_busy), 0);
    chk("stray_ntx", txq.size(), 0);

    // configuration with the reference gains
    kp = 16'h0003; ki = 16'h0001; kd = 16'hFFFE; sp = 16'h0064;
    lat_wr = 2;
    exp_cfg(kp, ki, kd, sp);
    req(1'b1, 1'b0, 1'b0);
    chk("cfg_busy", 32'(o_busy), 1);
    wait_idle("cfg");
    cmp_txs("cfg");

    // one sample: write PV, slow u(n) read
    lat_wr = 2; lat_rd = 10; un_val = 32'h0000_012C; of_val = $urandom;
    pv = 16'h0050;
    u0 = unv_hi;
    exp_pv(pv);
    req(1'b0, 1'b0, 1'b1);
    chk("pv_busy", 32'(o_busy), 1);
    wait_idle("pv");
    cmp_txs("pv");
    chk("pv_un", o_un, 32'h0000_012C);
    chk("pv_unv_cycles", unv_hi - u0, 1);
    chk("pv_un_at_valid", un_at_valid, exp_un);
    chk("pv_of", 32'(o_of), 32'(exp_of));

    // randomized requests
    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 2);
      lat_wr = $urandom_range(0, 12);
      lat_rd = $urandom_range(0, 12);
      un_val = $urandom;
      of_val = $urandom;
      pv = 16'($urandom);
      rnd_cfg_vals();
      u0 = unv_hi;
      if (kind == 0) begin
        exp_cfg(kp, ki, kd, sp);
        req(1'b1, 1'b0, 1'b0);
      end else if (kind == 1) begin
        exp_clr();
        req(1'b0, 1'b1, 1'b0);
      end else begin
        exp_pv(pv);
        req(1'b0, 1'b0, 1'b1);
      end
      wait_idle($sformatf("rnd%0d", it));
      cmp_txs($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_un", it), o_un, exp_un);
      chk($sformatf("rnd%0d_unv", it), unv_hi - u0, (kind == 2) ? 1 : 0);
      chk($sformatf("rnd%0d_of", it), 32'(o_of), 32'(exp_of));
    end

    // contention: cfg beats pv in the same cycle, then pv while busy
    lat_wr = 3;
    rnd_cfg_vals();
    exp_cfg(kp, ki, kd, sp);
    d0 = drop_hi; u0 = unv_hi;
    @(negedge clk);
    cfg = 1'b1; pvv = 1'b1;
    @(negedge clk);
    cfg = 1'b0; pvv = 1'b0;
    @(negedge clk);
    pvv = 1'b1;
    @(negedge clk);
    pvv = 1'b0;
    wait_idle("cont");
    cmp_txs("cont");
    chk("cont_drops", drop_hi - d0, 2);
    chk("cont_unv", unv_hi - u0, 0);

    // clear writes RS only and leaves o_un alone
    exp_clr();
    req(1'b0, 1'b1, 1'b0);
    wait_idle("clr");
    cmp_txs("clr");
    chk("clr_un", o_un, exp_un);

    // timeout on the u(n) read
    noack_un = 1'b1; lat_wr = 2;
    pv = 16'($urandom);
    u0 = unv_hi;
    expq.push_back(tx_t'{1'b1, 16'h0010, sx(pv)});
    req(1'b0, 1'b0, 1'b1);
    wait_idle("to");
    cmp_txs("to");
    chk("to_stb_len", last_len, TO);
    chk("to_err", 32'(o_err), 1);
    chk("to_unv", unv_hi - u0, 0);
    chk("to_un", o_un, exp_un);
    noack_un = 1'b0;

    // error flag survives a clear, cleared by a new configuration
    exp_clr();
    req(1'b0, 1'b1, 1'b0);
    wait_idle("err_clr_req");
    cmp_txs("err_clr_req");
    chk("err_sticky", 32'(o_err), 1);
    rnd_cfg_vals();
    exp_cfg(kp, ki, kd, sp);
    req(1'b1, 1'b0, 1'b0);
    wait_idle("err_cfg");
    cmp_txs("err_cfg");
    chk("err_cleared", 32'(o_err), 0);

    // reset in the middle of the PV write
    lat_wr = 15;
    pv = 16'($urandom);
    req(1'b0, 1'b0, 1'b1);
    n = 0;
    while (!wb.o_wb_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_stb_seen", 32'(wb.o_wb_stb), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_stb", 32'(wb.o_wb_stb), 0);
    chk("rstmid_cyc", 32'(wb.o_wb_cyc), 0);
    chk("rstmid_busy", 32'(o_busy), 0);
    exp_un = 32'h0;
    exp_of = 5'h0;
    chk("rstmid_un", o_un, exp_un);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    txq.delete();
    expq.delete();

    // a new sample completes normally after reset
    lat_wr = 2; lat_rd = 5; un_val = $urandom; of_val = 32'h0000_0005;
    pv = 16'($urandom);
    u0 = unv_hi;
    exp_pv(pv);
    req(1'b0, 1'b0, 1'b1);
    wait_idle("post_rst");
    cmp_txs("post_rst");
    chk("post_rst_un", o_un, exp_un);
    chk("post_rst_unv", unv_hi - u0, 1);
    chk("post_rst_of", 32'(o_of), 32'(exp_of));

    // protocol-wide observations
    chk("gap_viol", gap_viol, 0);
    chk("stab_viol", stab_viol, 0);
    chk("cyc_viol", cyc_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
